// File: rtl/mips16_ex_pkg.sv
// Shared types for the MIPS16 multi-cycle execute stage: opcodes, FSM states and sideband layout.
package mips16_ex_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_SRA = 4'd8,
    OP_LUI = 4'd9,
    OP_MUL = 4'd10
  } ex_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  localparam int EX_DEF_DATA_W     = 16;
  localparam int EX_DEF_REG_ADDR_W = 3;

  // Sideband layout for the default configuration; the stage mirrors it at its own widths.
  typedef struct packed {
    logic [EX_DEF_REG_ADDR_W-1:0] dest;
    logic                         wb_en;
    logic [1:0]                   mem_ctrl;
    logic [EX_DEF_DATA_W-1:0]     store_data;
  } ex_side_t;

endpackage

// File: rtl/mips16_ex_alu.sv
// Combinational single-cycle ALU; MUL and undefined codes yield zero here.
module mips16_ex_alu
  import mips16_ex_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] sh_amt;
  assign sh_amt = b_i[SH_W-1:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SLL:  result_o = a_i << sh_amt;
      OP_SRL:  result_o = a_i >> sh_amt;
      OP_SRA:  result_o = $signed(a_i) >>> sh_amt;
      OP_LUI:  result_o = b_i << (DATA_W / 2);
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/mips16_ex_stage_mc.sv
// Multi-cycle EX stage: one-cycle ALU ops, DATA_W-step shift-add multiply, valid/ready on both sides.
module mips16_ex_stage_mc
  import mips16_ex_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_alu_op,
  input  logic [DATA_W-1:0]     in_src_a,
  input  logic [DATA_W-1:0]     in_src_b,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic                  in_wb_en,
  input  logic [1:0]            in_mem_ctrl,
  input  logic [DATA_W-1:0]     in_store_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [DATA_W-1:0]     out_store_data,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic                  out_wb_en,
  output logic [1:0]            out_mem_ctrl,
  output logic [REG_ADDR_W-1:0] ex_op_dest,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic                  wb_en;
    logic [1:0]            mem_ctrl;
    logic [DATA_W-1:0]     store_data;
  } side_t;

  ex_state_e         state_q;
  logic [DATA_W-1:0] mul_a_q, mul_b_q, acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q;
  side_t             mul_side_q, out_side_q, in_side;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_result_q, alu_result;
  logic              out_free, accept;

  assign in_side  = '{dest: in_dest, wb_en: in_wb_en, mem_ctrl: in_mem_ctrl, store_data: in_store_data};
  assign out_free = !out_valid_q || out_ready;
  // rst gates in_ready so nothing is accepted while reset is held low.
  assign in_ready = rst && (state_q == ST_IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign acc_d    = acc_q + (mul_b_q[0] ? mul_a_q : '0);

  mips16_ex_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i    (in_alu_op),
    .a_i     (in_src_a),
    .b_i     (in_src_b),
    .result_o(alu_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      mul_side_q   <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_side_q   <= '0;
    end else begin
      // A drain clears the entry; a load later in this block overrides it.
      if (out_valid_q && out_ready) begin
        out_valid_q  <= 1'b0;
        out_result_q <= '0;
        out_side_q   <= '0;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (in_alu_op == OP_MUL) begin
              state_q    <= ST_MUL;
              mul_a_q    <= in_src_a;
              mul_b_q    <= in_src_b;
              acc_q      <= '0;
              cnt_q      <= '0;
              mul_side_q <= in_side;
            end else begin
              out_valid_q  <= 1'b1;
              out_result_q <= alu_result;
              out_side_q   <= in_side;
            end
          end
        end
        ST_MUL: begin
          acc_q   <= acc_d;
          mul_a_q <= mul_a_q << 1;
          mul_b_q <= mul_b_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (out_free) begin
            out_valid_q  <= 1'b1;
            out_result_q <= acc_q;
            out_side_q   <= mul_side_q;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ex_op_dest = '0;
    if ((state_q != ST_IDLE) && mul_side_q.wb_en) ex_op_dest = mul_side_q.dest;
    else if (out_valid_q && out_side_q.wb_en)     ex_op_dest = out_side_q.dest;
  end

  assign busy           = (state_q == ST_MUL);
  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_store_data = out_side_q.store_data;
  assign out_dest       = out_side_q.dest;
  assign out_wb_en      = out_side_q.wb_en;
  assign out_mem_ctrl   = out_side_q.mem_ctrl;

endmodule

// File: tb/tb_mips16_ex_stage_mc.sv
// Randomised check of the EX stage against a transaction-level model, plus directed DATA_W=16/32 cases.
module tb_mips16_ex_stage_mc;

  localparam int W  = 16;
  localparam int W2 = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DATA_W=16 instance
  logic          in_valid = 1'b0, in_ready, in_wb_en = 1'b0;
  logic [3:0]    in_alu_op = '0;
  logic [W-1:0]  in_src_a = '0, in_src_b = '0, in_store_data = '0;
  logic [2:0]    in_dest = '0;
  logic [1:0]    in_mem_ctrl = '0;
  logic          out_valid, out_ready = 1'b1, out_wb_en, busy;
  logic [W-1:0]  out_result, out_store_data;
  logic [2:0]    out_dest, ex_op_dest;
  logic [1:0]    out_mem_ctrl;

  mips16_ex_stage_mc #(.DATA_W(W), .REG_ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_dest(in_dest),
    .in_wb_en(in_wb_en), .in_mem_ctrl(in_mem_ctrl), .in_store_data(in_store_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_dest(out_dest), .out_wb_en(out_wb_en),
    .out_mem_ctrl(out_mem_ctrl), .ex_op_dest(ex_op_dest), .busy(busy)
  );

  // DATA_W=32 instance
  logic          in_valid32 = 1'b0, in_ready32;
  logic [3:0]    in_alu_op32 = '0;
  logic [W2-1:0] in_src_a32 = '0, in_src_b32 = '0;
  logic          out_valid32, out_ready32 = 1'b1, out_wb_en32, busy32;
  logic [W2-1:0] out_result32, out_store_data32;
  logic [2:0]    out_dest32, ex_op_dest32;
  logic [1:0]    out_mem_ctrl32;

  mips16_ex_stage_mc #(.DATA_W(W2), .REG_ADDR_W(3)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_alu_op(in_alu_op32),
    .in_src_a(in_src_a32), .in_src_b(in_src_b32), .in_dest(3'd4),
    .in_wb_en(1'b1), .in_mem_ctrl(2'b00), .in_store_data(32'h0),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_result(out_result32),
    .out_store_data(out_store_data32), .out_dest(out_dest32), .out_wb_en(out_wb_en32),
    .out_mem_ctrl(out_mem_ctrl32), .ex_op_dest(ex_op_dest32), .busy(busy32)
  );

  int checks = 0;
  int passed = 0;
  bit done32 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference results straight from the operation definitions.
  function automatic logic [W-1:0] ref_alu(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sh;
    logic signed [W-1:0] sa;
    logic [2*W-1:0] prod;
    sh = int'(b % W);
    sa = a;
    prod = a * b;
    case (op)
      1:  return a + b;
      2:  return a - b;
      3:  return a & b;
      4:  return a | b;
      5:  return a ^ b;
      6:  return a << sh;
      7:  return a >> sh;
      8:  return sa >>> sh;
      9:  return b << (W / 2);
      10: return prod[W-1:0];
      default: return '0;
    endcase
  endfunction

  // Transaction-level model: one output slot plus a multiply that becomes available W+1 edges after acceptance.
  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] sd;
    logic [2:0]   dest;
    logic         wb;
    logic [1:0]   mem;
  } ent_t;

  ent_t slot, pend, e;
  bit   slot_v = 1'b0, pend_v = 1'b0;
  int   cyc = 0, pend_rdy = 0;

  always @(posedge clk) begin
    bit free, take;
    if (!rst) begin
      slot_v = 1'b0;
      pend_v = 1'b0;
      cyc    = 0;
    end else begin
      cyc++;
      free = !slot_v || out_ready;
      take = in_valid && !pend_v && free;
      if (slot_v && out_ready) begin
        $display("xfer t=%0t result=%h dest=%0d wb=%0b mem=%b", $time, slot.res, slot.dest, slot.wb, slot.mem);
        slot_v = 1'b0;
      end
      if (take) begin
        e.res  = ref_alu(int'(in_alu_op), in_src_a, in_src_b);
        e.sd   = in_store_data;
        e.dest = in_dest;
        e.wb   = in_wb_en;
        e.mem  = in_mem_ctrl;
        if (in_alu_op == 4'd10) begin
          pend = e; pend_v = 1'b1; pend_rdy = cyc + W + 1;
        end else begin
          slot = e; slot_v = 1'b1;
        end
      end else if (pend_v && cyc >= pend_rdy && free) begin
        slot = pend; slot_v = 1'b1; pend_v = 1'b0;
      end
    end
  end

  // Compare every cycle, shortly after the active edge.
  always @(posedge clk) begin
    logic [2:0] exp_dest;
    #2;
    exp_dest = (pend_v && pend.wb) ? pend.dest : ((slot_v && slot.wb) ? slot.dest : 3'd0);
    chk("m_out_valid", 32'(out_valid), 32'(slot_v));
    chk("m_in_ready", 32'(in_ready), 32'(rst && !pend_v && (!slot_v || out_ready)));
    chk("m_busy", 32'(busy), 32'(pend_v && (cyc < pend_rdy - 1)));
    chk("m_ex_op_dest", 32'(ex_op_dest), 32'(exp_dest));
    if (slot_v) begin
      chk("m_result", 32'(out_result), 32'(slot.res));
      chk("m_store_data", 32'(out_store_data), 32'(slot.sd));
      chk("m_dest", 32'(out_dest), 32'(slot.dest));
      chk("m_wb_en", 32'(out_wb_en), 32'(slot.wb));
      chk("m_mem_ctrl", 32'(out_mem_ctrl), 32'(slot.mem));
    end
  end

  task automatic put(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int dest, input bit wb, input logic [1:0] mem, input logic [W-1:0] sd);
    in_valid      = 1'b1;
    in_alu_op     = 4'(op);
    in_src_a      = a;
    in_src_b      = b;
    in_dest       = 3'(dest);
    in_wb_en      = wb;
    in_mem_ctrl   = mem;
    in_store_data = sd;
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ex_op_dest"}, 32'(ex_op_dest), 0);
    chk({tag, "_result"}, 32'(out_result), 0);
    chk({tag, "_dest"}, 32'(out_dest), 0);
    chk({tag, "_wb_en"}, 32'(out_wb_en), 0);
    chk({tag, "_mem_ctrl"}, 32'(out_mem_ctrl), 0);
  endtask

  // Main DATA_W=16 stimulus
  initial begin
    int n, busy_n;
    bit rdy_seen, dest_bad;

    @(posedge clk); #1;
    check_reset_zero("rst0");
    @(negedge clk); rst = 1'b1;
    #1 chk("release_in_ready", 32'(in_ready), 1);

    // ADD overflow into sign bit, latency 1
    @(negedge clk); out_ready = 1'b1;
    put(1, 16'h7FFF, 16'h0001, 3, 1'b1, 2'b00, 16'h1234);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("add_valid", 32'(out_valid), 1);
    chk("add_result", 32'(out_result), 32'h8000);
    chk("add_dest", 32'(out_dest), 3);
    chk("add_wb_en", 32'(out_wb_en), 1);

    // SRA sign fill
    @(negedge clk); put(8, 16'h8000, 16'd15, 2, 1'b1, 2'b00, 16'h0);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("sra_result", 32'(out_result), 32'hFFFF);

    // MUL latency, busy length, in_ready and ex_op_dest during the operation
    @(negedge clk); put(10, 16'h00FF, 16'h0101, 5, 1'b1, 2'b00, 16'h0);
    @(posedge clk); #1; in_valid = 1'b0;
    n = 0; busy_n = 0; rdy_seen = 1'b0; dest_bad = 1'b0;
    while (!out_valid && n < 40) begin
      if (busy) busy_n++;
      if (in_ready) rdy_seen = 1'b1;
      if (ex_op_dest != 3'd5) dest_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("mul_latency", 32'(n), 17);
    chk("mul_busy_cycles", 32'(busy_n), 16);
    chk("mul_in_ready_low", 32'(rdy_seen), 0);
    chk("mul_ex_op_dest_held", 32'(dest_bad), 0);
    chk("mul_result", 32'(out_result), 32'hFFFF);
    chk("mul_ex_op_dest_out", 32'(ex_op_dest), 5);

    // Store with wb_en=0: no hazard destination, sideband forwarded
    @(negedge clk); put(1, 16'h0001, 16'h0002, 6, 1'b0, 2'b01, 16'hBEEF);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("store_ex_op_dest", 32'(ex_op_dest), 0);
    chk("store_mem_ctrl", 32'(out_mem_ctrl), 32'h1);
    chk("store_data", 32'(out_store_data), 32'hBEEF);
    @(posedge clk); #1;

    // Back-pressure with a second op waiting
    @(negedge clk); out_ready = 1'b0;
    put(2, 16'h0010, 16'h0003, 1, 1'b1, 2'b00, 16'h0);
    @(posedge clk); #1;
    chk("bp_first_result", 32'(out_result), 32'h000D);
    @(negedge clk); put(5, 16'hF0F0, 16'h0FF0, 2, 1'b1, 2'b10, 16'h0);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_held_result", 32'(out_result), 32'h000D);
      chk("bp_held_dest", 32'(out_dest), 1);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    chk("bp_second_valid", 32'(out_valid), 1);
    chk("bp_second_result", 32'(out_result), 32'hFF00);
    chk("bp_second_dest", 32'(out_dest), 2);
    @(posedge clk); #1;
    chk("bp_drained", 32'(out_valid), 0);

    // Random traffic with one mid-stream asynchronous reset
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (i == 600) begin
        rst = 1'b0; in_valid = 1'b0;
        #1 check_reset_zero("rst_mid");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_mid_release_in_ready", 32'(in_ready), 1);
      end else begin
        int op;
        op = ($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 15));
        put(op, 16'($urandom), ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom),
            int'($urandom_range(0, 7)), 1'($urandom), 2'($urandom), 16'($urandom));
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);

    chk("dut32_done", 32'(done32), 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // DATA_W=32 regression: full-width multiply and back-to-back ADD throughput
  initial begin
    int n;
    logic [W2-1:0] a, b;
    wait (rst === 1'b1);
    @(negedge clk);
    in_valid32 = 1'b1; in_alu_op32 = 4'd10;
    in_src_a32 = 32'hFFFF_FFFF; in_src_b32 = 32'hFFFF_FFFF;
    #1 chk("w32_mul_in_ready", 32'(in_ready32), 1);
    @(posedge clk); #1; in_valid32 = 1'b0;
    n = 0;
    while (!out_valid32 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w32_mul_latency", 32'(n), 33);
    chk("w32_mul_result", out_result32, 32'h0000_0001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 32'hFFFF_FFF0 + W2'(i);
      b = 32'h0000_0020;
      in_valid32 = 1'b1; in_alu_op32 = 4'd1; in_src_a32 = a; in_src_b32 = b;
      #1 chk("w32_add_in_ready", 32'(in_ready32), 1);
      @(posedge clk); #1;
      chk("w32_add_valid", 32'(out_valid32), 1);
      chk("w32_add_result", out_result32, 32'h10 + 32'(i));
    end
    in_valid32 = 1'b0;
    done32 = 1'b1;
  end

endmodule

// File: doc/mips16_ex_stage_mc.md
# mips16_ex_stage_mc

Parametrised multi-cycle execute stage for the MIPS16 pipeline, the successor to the single-cycle EX stage. It sits between the ID/EX and EX/MEM pipeline registers. Single-cycle ALU operations complete in one cycle; an iterative shift-add multiply takes DATA_W cycles. A valid/ready handshake on both sides lets it stall ID and absorb MEM back-pressure. It also exports the in-flight destination register for the hazard unit.

## Interface
Parameters:
- DATA_W, 16, datapath width; ≥4, power of two
- REG_ADDR_W, 3, register-file address width
- SH_W, $clog2(DATA_W), shift-amount width (derived, not overridable)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  ID/EX entry valid
- in_ready  out  1  stage can accept an entry this cycle
- in_alu_op  in  4  operation, ex_op_e encoding
- in_src_a / in_src_b  in  DATA_W  operands (already forwarded)
- in_dest  in  REG_ADDR_W  write-back register
- in_wb_en  in  1  write-back enable
- in_mem_ctrl  in  2  {mem_read, mem_write}, passed through
- in_store_data  in  DATA_W  store data, passed through
- out_valid  out  1  EX/MEM entry valid
- out_ready  in  1  MEM accepts entry
- out_result, out_store_data  out  DATA_W
- out_dest  out  REG_ADDR_W
- out_wb_en  out  1
- out_mem_ctrl  out  2
- ex_op_dest  out  REG_ADDR_W  destination of the instruction in EX or its output register when wb_en; 0 otherwise
- busy  out  1  multiply in progress

## Operation
- Ops:
  - NOP: result 0.
  - ADD, SUB: modulo 2^DATA_W.
  - AND, OR, XOR: bitwise.
  - SLL, SRL, SRA: amount = src_b[SH_W-1:0]; SRA sign-fills.
  - LUI: src_b << (DATA_W/2).
  - MUL: low DATA_W bits of a*b.
  - Undefined codes behave as NOP and keep wb_en/mem_ctrl.
- FSM:
  - IDLE: on accept, a single-cycle op loads the output register.
  - IDLE → MUL: on accept of MUL. Latches operands and sideband; acc=0; cnt=0.
  - MUL: each cycle, if b[0] then acc+=a; a<<=1; b>>=1; cnt++.
  - MUL → DONE: when cnt==DATA_W-1, after the final step.
  - DONE: loads the output register when it is free, then → IDLE.
- Output register: holds one entry. It clears when out_valid&&out_ready, unless it is reloaded in the same cycle.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Acceptance is in_valid&&in_ready.
- A NOP with in_wb_en=0 is still accepted and produces an out_valid bubble entry.
- ex_op_dest priority: the MUL/DONE latched dest, then the output-register dest. Each counts only if its wb_en is set.

## Timing
- Reset (rst low, async):
  - state=IDLE; out_valid=0.
  - All out_* data and sideband = 0; ex_op_dest=0; busy=0.
  - in_ready=0 while rst low; it is combinational after release.
- Single-cycle op accepted at edge k → out_valid=1 after edge k. With out_ready held high, one op per cycle.
- MUL accepted at edge k → busy=1 for cycles k+1..k+DATA_W. out_valid rises after edge k+DATA_W+1 if the output register is free.
- MUL throughput: in_ready=0 from acceptance until DONE drains.
- Back-pressure: while out_valid&&!out_ready, all out_* are stable. A MUL in DONE waits and keeps busy=0 and ex_op_dest set.
- Simultaneous drain and accept in one cycle: the output is overwritten with the new entry and out_valid stays 1.
- Reset mid-multiply: the operation is discarded with no partial output.

## Structure
- Package mips16_ex_pkg:
  - typedef enum logic [3:0] ex_op_e: NOP=0, ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, LUI, MUL.
  - typedef enum ex_state_e: IDLE, MUL, DONE.
  - Struct ex_side_t: dest, wb_en, mem_ctrl, store_data.
- Sub-module mips16_ex_alu: combinational single-cycle ALU, parametrised by DATA_W. The FSM and multiplier stay in the top.

## Test plan
- Reset: assert rst=0 mid-stream → all outputs 0 immediately. Release → in_ready=1 next cycle.
- ADD, DATA_W=16: 0x7FFF+0x0001 → out_result=0x8000, dest/wb_en forwarded, latency 1. SRA 0x8000 by 15 → 0xFFFF.
- MUL: 0x00FF*0x0101 → 0xFFFF, out_valid exactly 17 cycles after accept. busy=1 for 16 cycles; in_ready=0 throughout.
- Back-pressure: out_ready=0 for 5 cycles with a second op pending → in_ready=0 and out_* held. Both entries then drain in order.
- ex_op_dest: MUL to r5 with wb_en=1 → ex_op_dest=5 until the entry drains. A store (wb_en=0) → ex_op_dest=0.
- DATA_W=32 regression: 0xFFFFFFFF*0xFFFFFFFF → 0x00000001 in 33 cycles. Back-to-back ADDs sustain 1/cycle.
